imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 101 ++++++++++
 tb/tb_imem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction RAM between the fetch unit
// and an external loader/debug port. Fetch has priority; the external port
// is granted when fetch is idle or after MAX_STARVE consecutive denials.
module imem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_STARVE = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   // fetch port
   input  logic                  fetch_en,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_stall,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_valid,
   // external port
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_gnt,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  ext_rvalid,
   // memory port
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

   // owner of the RAM in the previous cycle; decides which read data is valid
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_FETCH  = 2'd1,
      OWN_EXT_RD = 2'd2
   } owner_t;

   owner_t           owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             grant_ext, grant_fetch;

   // state register: previous owner and external starvation count
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   // grant decision, RAM steering, next owner and starvation count
   always_comb begin
      grant_ext   = 1'b0;
      grant_fetch = 1'b0;
      owner_d     = OWN_NONE;
      starve_d    = '0;
      fetch_stall = 1'b0;
      fetch_valid = 1'b0;
      ext_gnt     = 1'b0;
      ext_rvalid  = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = fetch_addr;
      ram_wdata   = ext_wdata;
      fetch_data  = ram_rdata;
      ext_rdata   = ram_rdata;

      if (!reset) begin
         grant_ext   = ext_req && (!fetch_en || (starve_q == STARVE_MAX));
         grant_fetch = fetch_en && !grant_ext;

         fetch_valid = (owner_q == OWN_FETCH);
         ext_rvalid  = (owner_q == OWN_EXT_RD);
         fetch_stall = fetch_en && grant_ext;
         ext_gnt     = grant_ext;

         if (grant_ext) begin
            ram_en   = 1'b1;
            ram_we   = ext_we;
            ram_addr = ext_addr;
            owner_d  = ext_we ? OWN_NONE : OWN_EXT_RD;
         end else if (grant_fetch) begin
            ram_en   = 1'b1;
            owner_d  = OWN_FETCH;
         end

         // a forced grant clears the count, handing priority back to fetch
         if (ext_req && !grant_ext) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: two instances (MAX_STARVE 8 and 1), each
// with its own one-cycle-latency RAM model, driven by shared stimulus.
module tb_imem_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_en;
   logic [AW-1:0] fetch_addr;
   logic          ext_req, ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;

   // instance 0 (MAX_STARVE=8)
   logic          fetch_stall0, fetch_valid0, ext_gnt0, ext_rvalid0, ram_en0, ram_we0;
   logic [DW-1:0] fetch_data0, ext_rdata0, ram_wdata0, ram_rdata0;
   logic [AW-1:0] ram_addr0;
   // instance 1 (MAX_STARVE=1)
   logic          fetch_stall1, fetch_valid1, ext_gnt1, ext_rvalid1, ram_en1, ram_we1;
   logic [DW-1:0] fetch_data1, ext_rdata1, ram_wdata1, ram_rdata1;
   logic [AW-1:0] ram_addr1;

   logic [DW-1:0] mem0 [1024];
   logic [DW-1:0] mem1 [1024];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(8)) dut0 (
      .clk(clk), .reset(reset),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall0),
      .fetch_data(fetch_data0), .fetch_valid(fetch_valid0),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt0), .ext_rdata(ext_rdata0), .ext_rvalid(ext_rvalid0),
      .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
      .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
   );

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(1)) dut1 (
      .clk(clk), .reset(reset),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall1),
      .fetch_data(fetch_data1), .fetch_valid(fetch_valid1),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt1), .ext_rdata(ext_rdata1), .ext_rvalid(ext_rvalid1),
      .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
      .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
   );

   // single-port RAMs with one-cycle read latency
   always @(posedge clk) begin
      if (ram_en0) begin
         if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
         else         ram_rdata0      <= mem0[ram_addr0];
      end
      if (ram_en1) begin
         if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
         else         ram_rdata1      <= mem1[ram_addr1];
      end
   end

   // initial RAM contents: word i holds 0x1000_0000 + 7*i
   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h1000_0000 + DW'(i * 7);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int m_starve;
      int ext_wait;
      logic exp_gnt, prev_rd;

      for (int i = 0; i < 1024; i++) begin
         mem0[i] = init_word(i);
         mem1[i] = init_word(i);
      end
      ram_rdata0 = '0;
      ram_rdata1 = '0;

      // reset with both requesters active: everything idle
      reset = 1'b1; fetch_en = 1'b1; fetch_addr = '0;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'd3; ext_wdata = '0;
      for (int c = 0; c < 3; c++) begin
         cyc(); #1;
         check("rst_stall",  32'(fetch_stall0), 32'd0);
         check("rst_gnt",    32'(ext_gnt0),     32'd0);
         check("rst_ram_en", 32'(ram_en0),      32'd0);
         check("rst_ram_we", 32'(ram_we0),      32'd0);
         check("rst_fvalid", 32'(fetch_valid0), 32'd0);
         check("rst_rvalid", 32'(ext_rvalid0),  32'd0);
      end

      // continuous fetch 0..15, no external traffic
      ext_req = 1'b0;
      for (int c = 0; c <= 16; c++) begin
         cyc();
         reset = 1'b0;
         fetch_en = (c < 16);
         fetch_addr = AW'(c);
         #1;
         if (c < 16) begin
            check("seq_stall",  32'(fetch_stall0), 32'd0);
            check("seq_ram_en", 32'(ram_en0),      32'd1);
            check("seq_addr",   32'(ram_addr0),    32'(c));
         end
         check("seq_fvalid", 32'(fetch_valid0), (c == 0) ? 32'd0 : 32'd1);
         if (c > 0) check("seq_fdata", fetch_data0, init_word(c - 1));
      end

      // starvation-forced read of 286 under continuous fetch
      for (int c = 1; c <= 10; c++) begin
         cyc();
         fetch_en = 1'b1;
         fetch_addr = AW'(100 + c);
         ext_req = (c <= 9); ext_we = 1'b0; ext_addr = 10'd286;
         #1;
         check("stv_gnt",   32'(ext_gnt0),     (c == 9) ? 32'd1 : 32'd0);
         check("stv_stall", 32'(fetch_stall0), (c == 9) ? 32'd1 : 32'd0);
         if (c == 9) check("stv_addr", 32'(ram_addr0), 32'd286);
         check("stv_rvalid", 32'(ext_rvalid0), (c == 10) ? 32'd1 : 32'd0);
         if (c == 10) begin
            check("stv_rdata",  ext_rdata0, init_word(286));
            check("stv_fvalid", 32'(fetch_valid0), 32'd0);
         end
      end

      // back-to-back external write then read of 61, fetch idle
      cyc();
      fetch_en = 1'b0; ext_req = 1'b1; ext_we = 1'b1;
      ext_addr = 10'd61; ext_wdata = 32'hDEAD_BEEF;
      #1;
      check("wr_gnt",    32'(ext_gnt0), 32'd1);
      check("wr_ram_we", 32'(ram_we0),  32'd1);
      cyc();
      ext_we = 1'b0;
      #1;
      check("rd_gnt",       32'(ext_gnt0),    32'd1);
      check("rd_ram_we",    32'(ram_we0),     32'd0);
      check("wr_no_rvalid", 32'(ext_rvalid0), 32'd0);
      cyc();
      ext_req = 1'b0;
      #1;
      check("rd_rvalid", 32'(ext_rvalid0), 32'd1);
      check("rd_rdata",  ext_rdata0,       32'hDEAD_BEEF);
      check("idle_en",   32'(ram_en0),     32'd0);

      // random traffic against a reference grant model (MAX_STARVE=8)
      m_starve = 0; ext_wait = 0; prev_rd = 1'b0; exp_gnt = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         cyc();
         fetch_en = ($urandom_range(3) != 0);
         fetch_addr = AW'($urandom_range(1023));
         if (!ext_req || exp_gnt) begin
            ext_req   = ($urandom_range(2) == 0);
            ext_we    = $urandom_range(1) == 1;
            ext_addr  = AW'(512 + $urandom_range(511));
            ext_wdata = DW'($urandom);
         end
         #1;
         exp_gnt = ext_req && (!fetch_en || m_starve == 8);
         check("rnd_gnt",    32'(ext_gnt0),     32'(exp_gnt));
         check("rnd_stall",  32'(fetch_stall0), 32'(fetch_en && exp_gnt));
         check("rnd_ram_en", 32'(ram_en0),      32'(fetch_en || exp_gnt));
         check("rnd_rvalid", 32'(ext_rvalid0),  32'(prev_rd));
         if (ext_req) begin
            ext_wait++;
            if (exp_gnt) begin
               check("rnd_wait", 32'(ext_wait <= 9), 32'd1);
               ext_wait = 0;
            end
         end
         prev_rd  = exp_gnt && !ext_we;
         m_starve = (!ext_req || exp_gnt) ? 0 : ((m_starve < 8) ? m_starve + 1 : 8);
      end

      // reset right after an external read grant discards the read
      cyc();
      fetch_en = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'd5;
      #1;
      check("rf_gnt", 32'(ext_gnt0), 32'd1);
      for (int c = 0; c < 2; c++) begin
         cyc();
         reset = 1'b1; ext_req = 1'b0;
         #1;
         check("rf_rst_rvalid", 32'(ext_rvalid0), 32'd0);
         check("rf_rst_gnt",    32'(ext_gnt0),    32'd0);
      end
      cyc();
      reset = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'd7;
      #1;
      check("rf_post_rvalid", 32'(ext_rvalid0), 32'd0);
      check("rf_first_gnt",   32'(ext_gnt0),    32'd1);
      check("rf_first_addr",  32'(ram_addr0),   32'd7);
      cyc();
      ext_req = 1'b0;
      #1;
      check("rf_rvalid", 32'(ext_rvalid0), 32'd1);
      check("rf_rdata",  ext_rdata0,       init_word(7));

      // MAX_STARVE=1: four reads alternate with fetch grants
      n = 0;
      for (int c = 0; c <= 8; c++) begin
         cyc();
         fetch_en = 1'b1;
         fetch_addr = AW'(300 + c);
         ext_req = (c < 8); ext_we = 1'b0; ext_addr = AW'(200 + n);
         #1;
         if (c < 8) begin
            check("alt_gnt",   32'(ext_gnt1),     32'(c % 2));
            check("alt_stall", 32'(fetch_stall1), 32'(c % 2));
         end
         if (c > 0) begin
            check("alt_rvalid", 32'(ext_rvalid1),  32'((c - 1) % 2));
            check("alt_fvalid", 32'(fetch_valid1), 32'(c % 2));
            if (c % 2 == 0) check("alt_rdata", ext_rdata1, init_word(200 + n - 1));
            else            check("alt_fdata", fetch_data1, init_word(300 + c - 1));
         end
         if (c % 2 == 1) n++;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
